// File: rtl/vad_pkg.sv
// vad_pkg: shared state encodings and accumulator width for the voice activity detector
package vad_pkg;
  typedef enum logic [1:0] {
    SILENCE  = 2'd0,
    ATTACK   = 2'd1,
    SPEECH   = 2'd2,
    HANGOVER = 2'd3
  } vad_state_e;
  function automatic int acc_w(input int data_w, input int frame_len_log2);
    return 2 * data_w + frame_len_log2;
  endfunction
endpackage

// File: rtl/vad_energy_acc.sv
// vad_energy_acc: square pipe, sample counter and per-frame mean-square accumulator
module vad_energy_acc
  import vad_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int FRAME_LEN_LOG2 = 8,
  parameter int ENERGY_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic [ENERGY_W-1:0]      frame_energy,
  output logic                     energy_valid
);
  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = acc_w(DATA_W, FRAME_LEN_LOG2);
  logic [FRAME_LEN_LOG2-1:0] cnt_q;
  logic [SQ_W-1:0]           sq_q;
  logic                      sq_vld_q, sq_last_q, ev_q;
  logic [ACC_W-1:0]          acc_q, sum;
  logic [ENERGY_W-1:0]       energy_q;
  logic signed [SQ_W-1:0]    prod;
  logic                      accept;
  assign accept = enable & sample_valid;
  // Most-negative input squares to 2**(SQ_W-2), still positive in SQ_W signed bits
  assign prod = SQ_W'(sample_in) * SQ_W'(sample_in);
  assign sum  = acc_q + ACC_W'(sq_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      sq_q      <= '0;
      sq_vld_q  <= 1'b0;
      sq_last_q <= 1'b0;
      acc_q     <= '0;
      energy_q  <= '0;
      ev_q      <= 1'b0;
    end else if (!enable) begin
      cnt_q     <= '0;
      sq_q      <= '0;
      sq_vld_q  <= 1'b0;
      sq_last_q <= 1'b0;
      acc_q     <= '0;
      energy_q  <= '0;
      ev_q      <= 1'b0;
    end else begin
      sq_vld_q  <= accept;
      sq_last_q <= accept && (cnt_q == '1);
      if (accept) begin
        sq_q  <= $unsigned(prod);
        cnt_q <= cnt_q + FRAME_LEN_LOG2'(1);
      end
      ev_q <= sq_vld_q && sq_last_q;
      if (sq_vld_q) begin
        acc_q <= sq_last_q ? '0 : sum;
        if (sq_last_q) energy_q <= ENERGY_W'(sum >> FRAME_LEN_LOG2);
      end
    end
  end
  assign frame_energy = energy_q;
  assign energy_valid = ev_q;
endmodule

// File: rtl/voice_activity_detector.sv
// voice_activity_detector: frame energy plus speech/silence decision with attack and hangover
module voice_activity_detector
  import vad_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int FRAME_LEN_LOG2 = 8,
  parameter int ATTACK_FRAMES  = 2,
  parameter int HANG_FRAMES    = 8,
  parameter int ENERGY_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic [ENERGY_W-1:0]      thr_on,
  input  logic [ENERGY_W-1:0]      thr_off,
  output logic [ENERGY_W-1:0]      frame_energy,
  output logic                     energy_valid,
  output logic                     vad_flag,
  output logic [1:0]               vad_state
);
  localparam int AW = $clog2(ATTACK_FRAMES + 1);
  localparam int HW = $clog2(HANG_FRAMES + 1);
  vad_state_e state_q;
  logic [AW-1:0] att_cnt_q;
  logic [HW-1:0] hang_cnt_q;
  vad_energy_acc #(
    .DATA_W        (DATA_W),
    .FRAME_LEN_LOG2(FRAME_LEN_LOG2),
    .ENERGY_W      (ENERGY_W)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .frame_energy(frame_energy),
    .energy_valid(energy_valid)
  );
  // Decision runs on the energy_valid cycle so the new state is visible one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SILENCE;
      att_cnt_q  <= '0;
      hang_cnt_q <= '0;
    end else if (!enable) begin
      state_q    <= SILENCE;
      att_cnt_q  <= '0;
      hang_cnt_q <= '0;
    end else if (energy_valid) begin
      case (state_q)
        SILENCE:
          if (frame_energy >= thr_on) begin
            state_q   <= (ATTACK_FRAMES == 1) ? SPEECH : ATTACK;
            att_cnt_q <= AW'(1);
          end
        ATTACK:
          if (frame_energy < thr_on) state_q <= SILENCE;
          else if (att_cnt_q + AW'(1) == AW'(ATTACK_FRAMES)) state_q <= SPEECH;
          else att_cnt_q <= att_cnt_q + AW'(1);
        SPEECH:
          if (frame_energy < thr_off) begin
            state_q    <= HANGOVER;
            hang_cnt_q <= HW'(HANG_FRAMES - 1);
          end
        HANGOVER:
          if (frame_energy >= thr_off) state_q <= SPEECH;
          else if (hang_cnt_q == '0) state_q <= SILENCE;
          else hang_cnt_q <= hang_cnt_q - HW'(1);
        default: state_q <= SILENCE;
      endcase
    end
  end
  assign vad_state = state_q;
  assign vad_flag  = state_q[1];
endmodule
